// File: rtl/dm_pkg.sv
// Debug-module types shared between the DTM and the DM: DMI request/response
// structs, DTM op encodings and the sticky DMI status codes reported on capture.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    // Status reported in the op field of the DR on capture.
    localparam logic [1:0] DMINoError  = 2'h0;
    localparam logic [1:0] DMIOpFailed = 2'h2;
    localparam logic [1:0] DMIBusy     = 2'h3;

endpackage

// File: rtl/dmi_initiator.sv
// DTM-side DMI requester: issues one DMI transaction per JTAG DR update and keeps
// the response data plus a sticky error status for the next DR capture.
module dmi_initiator
    import dm::*;
#(
    parameter int unsigned AbitsW = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              update_i,
    input  logic              capture_i,
    input  logic [AbitsW-1:0] dr_addr_i,
    input  logic [1:0]        dr_op_i,
    input  logic [31:0]       dr_data_i,
    input  logic              dmireset_i,
    input  logic              dmihardreset_i,
    output logic [AbitsW-1:0] dr_addr_o,
    output logic [31:0]       dr_data_o,
    output logic [1:0]        dr_op_o,
    output logic              busy_o,
    output logic              dmi_req_valid_o,
    output dmi_req_t          dmi_req_o,
    input  logic              dmi_req_ready_i,
    input  logic              dmi_resp_valid_i,
    input  dmi_resp_t         dmi_resp_i,
    output logic              dmi_resp_ready_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    dmi_req_t          req_q, req_d;
    logic [AbitsW-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        error_q, error_d;

    logic new_req;

    assign busy_o   = (state_q != IDLE);
    assign new_req  = update_i && !dmireset_i && (error_q == DMINoError) &&
                      ((dr_op_i == DTM_READ) || (dr_op_i == DTM_WRITE));

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        error_d = error_q;

        if (dmihardreset_i) begin
            // Abort everything; a late response is simply absorbed in IDLE.
            state_d = IDLE;
            error_d = DMINoError;
        end else begin
            if (dmireset_i) error_d = DMINoError;

            unique case (state_q)
                IDLE: begin
                    if (new_req) begin
                        req_d.addr = dr_addr_i;
                        req_d.op   = dtm_op_e'(dr_op_i);
                        req_d.data = dr_data_i;
                        addr_d     = dr_addr_i;
                        state_d    = REQ;
                    end
                end
                REQ: begin
                    if (dmi_req_ready_i) state_d = WAIT_RESP;
                end
                WAIT_RESP: begin
                    if (dmi_resp_valid_i) begin
                        data_d  = dmi_resp_i.data;
                        state_d = IDLE;
                        // A pending busy status outranks a failed op.
                        if (dmi_resp_i.resp != DTM_SUCCESS && error_d != DMIBusy)
                            error_d = DMIOpFailed;
                    end
                end
                default: state_d = IDLE;
            endcase

            if ((update_i || capture_i) && busy_o && !dmireset_i) error_d = DMIBusy;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= DMINoError;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    // Hard reset drops valid combinationally so an unaccepted request is withdrawn at once.
    assign dmi_req_valid_o  = (state_q == REQ) && !dmihardreset_i;
    assign dmi_req_o        = req_q;
    assign dmi_resp_ready_o = 1'b1;
    assign dr_addr_o        = addr_q;
    assign dr_data_o        = data_q;
    assign dr_op_o          = error_q;

endmodule

// File: tb/tb_dmi_initiator.sv
// Directed bench for dmi_initiator: read, write with backpressure, busy, failed op,
// hard reset and asynchronous reset scenarios against hand-computed values.
module tb_dmi_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        update = 1'b0;
    logic        capture = 1'b0;
    logic [6:0]  dr_addr_in = '0;
    logic [1:0]  dr_op_in = '0;
    logic [31:0] dr_data_in = '0;
    logic        dmireset = 1'b0;
    logic        dmihardreset = 1'b0;
    logic [6:0]  dr_addr_out;
    logic [31:0] dr_data_out;
    logic [1:0]  dr_op_out;
    logic        busy;
    logic        req_valid;
    dm::dmi_req_t req;
    logic        req_ready = 1'b0;
    logic        resp_valid = 1'b0;
    dm::dmi_resp_t resp;
    logic        resp_ready;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    dmi_initiator #(.AbitsW(7)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .update_i         (update),
        .capture_i        (capture),
        .dr_addr_i        (dr_addr_in),
        .dr_op_i          (dr_op_in),
        .dr_data_i        (dr_data_in),
        .dmireset_i       (dmireset),
        .dmihardreset_i   (dmihardreset),
        .dr_addr_o        (dr_addr_out),
        .dr_data_o        (dr_data_out),
        .dr_op_o          (dr_op_out),
        .busy_o           (busy),
        .dmi_req_valid_o  (req_valid),
        .dmi_req_o        (req),
        .dmi_req_ready_i  (req_ready),
        .dmi_resp_valid_i (resp_valid),
        .dmi_resp_i       (resp),
        .dmi_resp_ready_o (resp_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && req_valid && req_ready) hs_cnt <= hs_cnt + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        update = 1'b1; dr_op_in = op; dr_addr_in = addr; dr_data_in = data;
        tick();
        update = 1'b0;
    endtask

    task automatic do_resp(input logic [31:0] data, input logic [1:0] code);
        resp_valid = 1'b1; resp = {data, code};
        tick();
        resp_valid = 1'b0;
    endtask

    task automatic test_reset;
        resp = '0;
        tick(); tick();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", req_valid); end
        checks++; if (req !== 41'h0) begin errors++; $display("FAIL reset_req got %h want 0", req); end
        checks++; if ({dr_addr_out, dr_data_out, dr_op_out, busy} !== 42'h0)
            begin errors++; $display("FAIL reset_outs got %h/%h/%h/%b want 0", dr_addr_out, dr_data_out, dr_op_out, busy); end
        rst_n = 1'b1;
        tick();
        checks++; if (resp_ready !== 1'b1) begin errors++; $display("FAIL resp_ready got %b want 1", resp_ready); end
    endtask

    task automatic test_nop;
        do_update(2'd0, 7'h05, 32'h1);
        checks++; if (busy !== 1'b0 || req_valid !== 1'b0) begin errors++; $display("FAIL nop_busy got %b/%b want 0/0", busy, req_valid); end
        do_update(2'd3, 7'h06, 32'h2);
        checks++; if (busy !== 1'b0 || dr_op_out !== 2'd0) begin errors++; $display("FAIL rsvd_op got %b/%h want 0/0", busy, dr_op_out); end
    endtask

    task automatic test_read;
        int hs0;
        hs0 = hs_cnt;
        req_ready = 1'b1;
        do_update(2'd1, 7'h11, 32'h0);
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL rd_valid got %b want 1", req_valid); end
        checks++; if (req !== {7'h11, 2'd1, 32'h0}) begin errors++; $display("FAIL rd_req got %h want %h", req, {7'h11, 2'd1, 32'h0}); end
        tick();
        checks++; if (req_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_wait got %b/%b want 0/1", req_valid, busy); end
        do_resp(32'hDEAD_BEEF, 2'd0);
        checks++; if (dr_data_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", dr_data_out); end
        checks++; if (dr_op_out !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL rd_status got %h/%b want 0/0", dr_op_out, busy); end
        checks++; if (dr_addr_out !== 7'h11 || hs_cnt - hs0 !== 1) begin errors++; $display("FAIL rd_addr_hs got %h/%0d want 11/1", dr_addr_out, hs_cnt - hs0); end
    endtask

    task automatic test_write_backpressure;
        int hs0;
        hs0 = hs_cnt;
        req_ready = 1'b0;
        do_update(2'd2, 7'h04, 32'h1234);
        for (int i = 0; i < 5; i++) begin
            checks++; if (req_valid !== 1'b1 || req !== {7'h04, 2'd2, 32'h1234})
                begin errors++; $display("FAIL wr_hold%0d got %b/%h want 1/%h", i, req_valid, req, {7'h04, 2'd2, 32'h1234}); end
            tick();
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        checks++; if (req_valid !== 1'b0 || hs_cnt - hs0 !== 1) begin errors++; $display("FAIL wr_hs got %b/%0d want 0/1", req_valid, hs_cnt - hs0); end
        tick();
        do_resp(32'hCAFE_0000, 2'd0);
        checks++; if (dr_op_out !== 2'd0 || dr_data_out !== 32'hCAFE_0000 || busy !== 1'b0)
            begin errors++; $display("FAIL wr_done got %h/%h/%b want 0/cafe0000/0", dr_op_out, dr_data_out, busy); end
        checks++; if (hs_cnt - hs0 !== 1) begin errors++; $display("FAIL wr_one_hs got %0d want 1", hs_cnt - hs0); end
    endtask

    task automatic test_busy;
        int hs0;
        hs0 = hs_cnt;
        req_ready = 1'b1;
        do_update(2'd1, 7'h20, 32'h0);
        tick();
        do_update(2'd2, 7'h21, 32'h9);
        checks++; if (dr_op_out !== 2'd3 || busy !== 1'b1 || dr_addr_out !== 7'h20)
            begin errors++; $display("FAIL busy_err got %h/%b/%h want 3/1/20", dr_op_out, busy, dr_addr_out); end
        do_resp(32'h0000_0055, 2'd0);
        checks++; if (dr_op_out !== 2'd3 || dr_data_out !== 32'h55) begin errors++; $display("FAIL busy_sticky got %h/%h want 3/55", dr_op_out, dr_data_out); end
        do_update(2'd1, 7'h22, 32'h0);
        checks++; if (req_valid !== 1'b0 || busy !== 1'b0 || hs_cnt - hs0 !== 1)
            begin errors++; $display("FAIL busy_ignore got %b/%b/%0d want 0/0/1", req_valid, busy, hs_cnt - hs0); end
        // Update coinciding with dmireset must be dropped.
        dmireset = 1'b1;
        do_update(2'd1, 7'h24, 32'h0);
        dmireset = 1'b0;
        checks++; if (dr_op_out !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL dmireset got %h/%b want 0/0", dr_op_out, busy); end
        do_update(2'd1, 7'h23, 32'h0);
        checks++; if (req_valid !== 1'b1 || req !== {7'h23, 2'd1, 32'h0}) begin errors++; $display("FAIL busy_next got %b/%h want 1/%h", req_valid, req, {7'h23, 2'd1, 32'h0}); end
        tick();
        do_resp(32'h0000_0066, 2'd0);
        checks++; if (dr_op_out !== 2'd0 || hs_cnt - hs0 !== 2) begin errors++; $display("FAIL busy_done got %h/%0d want 0/2", dr_op_out, hs_cnt - hs0); end
    endtask

    task automatic test_failed_op;
        int hs0;
        req_ready = 1'b1;
        do_update(2'd1, 7'h30, 32'h0);
        tick();
        do_resp(32'h0000_0077, 2'd2);
        checks++; if (dr_op_out !== 2'd2 || dr_data_out !== 32'h77) begin errors++; $display("FAIL fail_err got %h/%h want 2/77", dr_op_out, dr_data_out); end
        hs0 = hs_cnt;
        do_update(2'd1, 7'h31, 32'h0);
        tick();
        checks++; if (req_valid !== 1'b0 || busy !== 1'b0 || hs_cnt !== hs0 || dr_op_out !== 2'd2)
            begin errors++; $display("FAIL fail_block got %b/%b/%0d/%h want 0/0/%0d/2", req_valid, busy, hs_cnt, dr_op_out, hs0); end
        dmireset = 1'b1; tick(); dmireset = 1'b0;
        checks++; if (dr_op_out !== 2'd0) begin errors++; $display("FAIL fail_clear got %h want 0", dr_op_out); end
    endtask

    task automatic test_hardreset;
        int hs0;
        hs0 = hs_cnt;
        req_ready = 1'b0;
        do_update(2'd1, 7'h40, 32'h0);
        capture = 1'b1; tick(); capture = 1'b0;
        checks++; if (req_valid !== 1'b1 || dr_op_out !== 2'd3) begin errors++; $display("FAIL hr_pre got %b/%h want 1/3", req_valid, dr_op_out); end
        dmihardreset = 1'b1;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL hr_valid_now got %b want 0", req_valid); end
        tick();
        dmihardreset = 1'b0;
        checks++; if (req_valid !== 1'b0 || busy !== 1'b0 || dr_op_out !== 2'd0)
            begin errors++; $display("FAIL hr_idle got %b/%b/%h want 0/0/0", req_valid, busy, dr_op_out); end
        do_resp(32'h0000_0099, 2'd2);
        checks++; if (dr_data_out !== 32'h77 || dr_op_out !== 2'd0 || hs_cnt !== hs0)
            begin errors++; $display("FAIL hr_stray got %h/%h/%0d want 77/0/%0d", dr_data_out, dr_op_out, hs_cnt, hs0); end
    endtask

    task automatic test_async_reset;
        req_ready = 1'b1;
        do_update(2'd2, 7'h50, 32'hAAAA);
        tick();
        checks++; if (busy !== 1'b1 || req_valid !== 1'b0) begin errors++; $display("FAIL ar_pre got %b/%b want 1/0", busy, req_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({req_valid, req, dr_addr_out, dr_data_out, dr_op_out, busy} !== 84'h0)
            begin errors++; $display("FAIL ar_outs got %b/%h/%h/%h/%h/%b want all 0", req_valid, req, dr_addr_out, dr_data_out, dr_op_out, busy); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nop();
        test_read();
        test_write_backpressure();
        test_busy();
        test_failed_op();
        test_hardreset();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
